// File: rtl/event_det_pkg.sv
// Shared definitions for the multi-channel event detector.
//   EDGE_*  : per-channel edge-select codes carried on the mode bus
//   clog2   : bits needed to hold values 0 .. value-1, used to size the filter counter
package event_det_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/event_det_channel.sv
// One detector channel: synchroniser, glitch filter, edge detect, sticky
// pending flag and saturating event counter.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   data     in   asynchronous raw input
//   mode     in   edge select (off / rise / fall / both)
//   clear    in   write-1-clear strobe for pending and count
//   evt      out  one-cycle registered pulse per qualifying filtered edge
//   pending  out  sticky flag set by evt
//   count    out  saturating event count
module event_det_channel
  import event_det_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             evt,
  output logic             pending,
  output logic [CNT_W-1:0] count
);

  localparam int                FILT_W    = (clog2(FILTER_CYCLES) < 1) ? 1 : clog2(FILTER_CYCLES);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   filt;
  logic                   filt_d;
  logic [FILT_W-1:0]      filt_cnt;
  logic                   rise;
  logic                   fall;
  logic                   hit;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rise = filt & ~filt_d;
    fall = ~filt & filt_d;
    hit  = 1'b0;
    case (mode)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours (the sync chain shifts
  // correctly and filt_d really is last cycle's filt).
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the synchroniser chain is reset too, so a level seen before
      // reset cannot leak into the filter as a stale edge after release.
      sync_q   <= '0;
      filt     <= 1'b0;
      filt_d   <= 1'b0;
      filt_cnt <= '0;
      evt      <= 1'b0;
      pending  <= 1'b0;
      count    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data};
      filt_d <= filt;

      // Filtered level only follows the synchronised input after it has
      // disagreed for FILTER_CYCLES consecutive samples.
      if (sync_q[SYNC_STAGES-1] != filt) begin
        if (filt_cnt == FILT_LAST) begin
          filt     <= ~filt;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FILT_W'(1);
        end
      end else begin
        filt_cnt <= '0;
      end

      evt <= hit;

      // A clear and an event in the same cycle: clear first, then count the event.
      if (hit)        pending <= 1'b1;
      else if (clear) pending <= 1'b0;

      if (clear)                         count <= hit ? CNT_W'(1) : '0;
      else if (hit && count != CNT_MAX)  count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_channel_event_detector.sv
// NUM_CH independent event-detector channels plus a shared, maskable IRQ.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   i_Data     in   NUM_CH asynchronous event inputs
//   i_Mode     in   2 bits per channel at [2c+1:2c]: off / rise / fall / both
//   i_Clear    in   per-channel write-1-clear of pending flag and count
//   i_Irq_En   in   per-channel IRQ enable mask
//   o_Event    out  one-cycle pulse per detected edge
//   o_Pending  out  sticky per-channel event flags
//   o_Count    out  saturating counts, channel c at [CNT_W*c +: CNT_W]
//   o_Irq      out  registered OR of enabled pending flags
module multi_channel_event_detector
  import event_det_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       i_Data,
  input  logic [2*NUM_CH-1:0]     i_Mode,
  input  logic [NUM_CH-1:0]       i_Clear,
  input  logic [NUM_CH-1:0]       i_Irq_En,
  output logic [NUM_CH-1:0]       o_Event,
  output logic [NUM_CH-1:0]       o_Pending,
  output logic [CNT_W*NUM_CH-1:0] o_Count,
  output logic                    o_Irq
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    event_det_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .CNT_W         (CNT_W)
    ) u_channel (
      .clk     (clk),
      .reset   (reset),
      .data    (i_Data[c]),
      .mode    (i_Mode[2*c +: 2]),
      .clear   (i_Clear[c]),
      .evt     (o_Event[c]),
      .pending (o_Pending[c]),
      .count   (o_Count[CNT_W*c +: CNT_W])
    );
  end

  // IRQ follows the registered pending flags, so it trails o_Pending by one cycle.
  always_ff @(posedge clk) begin
    if (reset) o_Irq <= 1'b0;
    else       o_Irq <= |(o_Pending & i_Irq_En);
  end

endmodule
